// File: rtl/tournament_pkg.sv
// Shared widths, queue entry layout and flush FSM states
// for the tournament predictor resolution path.
package tournament_pkg;
   localparam int DEF_DEPTH = 8;
   localparam int DEF_PC_W  = 32;
   localparam int DEF_GHR_W = 12;
   localparam int DEF_LHT_W = 10;

   typedef struct packed {
      logic [DEF_PC_W-1:0]  pc;
      logic                 global_pred;
      logic                 local_pred;
      logic                 taken;
      logic [DEF_GHR_W-1:0] ghr;
      logic [DEF_LHT_W-1:0] lht;
   } pred_entry_t;

   typedef enum logic {RUN, FLUSH} upd_state_t;
endpackage

// File: rtl/tournament_fifo.sv
// In-order queue of issued predictions; clear wins over push/pop.
module tournament_fifo
   import tournament_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        clear,
   input  logic        push,
   input  logic        pop,
   input  pred_entry_t din,
   output pred_entry_t dout,
   output logic        full,
   output logic        empty,
   output logic [AW:0] count
);
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   pred_entry_t   mem [DEPTH];
   logic          wr;
   logic          rd;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign wr    = push && !full;
   assign rd    = pop && !empty;
   assign dout  = mem[head];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (clear) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (wr) tail <= tail + 1'b1;
         if (rd) head <= head + 1'b1;
         unique case ({wr, rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // storage needs no reset: count gates every read
   always_ff @(posedge clock) begin
      if (wr && !clear) mem[tail] <= din;
   end
endmodule

// File: rtl/tournament_update.sv
// Retires resolved predictions and emits predictor training updates.
// Optional TOURNAMENT_STATS_EN adds saturating branch/mispredict counters.
module tournament_update
   import tournament_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int PC_W  = DEF_PC_W,
   parameter int GHR_W = DEF_GHR_W,
   parameter int LHT_W = DEF_LHT_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             pred_valid,
   output logic             pred_ready,
   input  logic [PC_W-1:0]  pred_pc,
   input  logic             pred_global,
   input  logic             pred_local,
   input  logic             pred_taken,
   input  logic [GHR_W-1:0] pred_ghr,
   input  logic [LHT_W-1:0] pred_lht,
   input  logic             res_valid,
   output logic             res_ready,
   input  logic             res_taken,
   output logic             upd_valid,
   output logic [PC_W-1:0]  upd_pc,
   output logic             upd_taken,
   output logic [GHR_W-1:0] upd_ghr,
   output logic [LHT_W-1:0] upd_lht,
   output logic             choice_upd_en,
   output logic             choice_to_global,
   output logic             mispredict,
   output logic [GHR_W-1:0] restore_ghr
`ifdef TOURNAMENT_STATS_EN
   ,
   output logic [31:0]      stat_branches,
   output logic [31:0]      stat_mispredicts
`endif
);
   localparam int AW = $clog2(DEPTH);

   upd_state_t  state;
   upd_state_t  state_nx;
   pred_entry_t wr_e;
   pred_entry_t hd;
   logic        full;
   logic        empty;
   logic [AW:0] unused_count;
   logic        run;
   logic        push_ok;
   logic        pop_ok;
   logic        miss;

   assign run        = (state == RUN);
   assign pred_ready = run && !full;
   assign res_ready  = run && !empty;
   assign push_ok    = pred_valid && pred_ready;
   assign pop_ok     = res_valid && res_ready;
   assign miss       = pop_ok && (hd.taken != res_taken);

   assign wr_e = '{pc: pred_pc, global_pred: pred_global,
                   local_pred: pred_local, taken: pred_taken,
                   ghr: pred_ghr, lht: pred_lht};

   // a mispredict clears the queue, dropping any same-cycle push
   tournament_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .clear (miss),
      .push  (push_ok),
      .pop   (pop_ok),
      .din   (wr_e),
      .dout  (hd),
      .full  (full),
      .empty (empty),
      .count (unused_count)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= RUN;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         RUN:     if (miss) state_nx = FLUSH;
         FLUSH:   state_nx = RUN;
         default: state_nx = RUN;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         upd_valid        <= 1'b0;
         upd_pc           <= '0;
         upd_taken        <= 1'b0;
         upd_ghr          <= '0;
         upd_lht          <= '0;
         choice_upd_en    <= 1'b0;
         choice_to_global <= 1'b0;
         mispredict       <= 1'b0;
         restore_ghr      <= '0;
      end else begin
         upd_valid     <= pop_ok;
         mispredict    <= miss;
         choice_upd_en <= pop_ok && (hd.global_pred != hd.local_pred);
         if (pop_ok) begin
            upd_pc           <= hd.pc;
            upd_taken        <= res_taken;
            upd_ghr          <= hd.ghr;
            upd_lht          <= hd.lht;
            choice_to_global <= (hd.global_pred == res_taken);
            restore_ghr      <= {hd.ghr[GHR_W-2:0], res_taken};
         end
      end
   end

`ifdef TOURNAMENT_STATS_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else begin
         if (upd_valid && stat_branches != '1)
            stat_branches <= stat_branches + 1'b1;
         if (mispredict && stat_mispredicts != '1)
            stat_mispredicts <= stat_mispredicts + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_tournament_update.sv
// Directed bench for tournament_update with hand-computed expectations.
module tb_tournament_update;
   logic        clock = 1'b0;
   logic        reset;
   logic        pred_valid;
   logic        pred_ready;
   logic [31:0] pred_pc;
   logic        pred_global;
   logic        pred_local;
   logic        pred_taken;
   logic [11:0] pred_ghr;
   logic [9:0]  pred_lht;
   logic        res_valid;
   logic        res_ready;
   logic        res_taken;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [11:0] upd_ghr;
   logic [9:0]  upd_lht;
   logic        choice_upd_en;
   logic        choice_to_global;
   logic        mispredict;
   logic [11:0] restore_ghr;
`ifdef TOURNAMENT_STATS_EN
   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   tournament_update dut (
      .clock            (clock),
      .reset            (reset),
      .pred_valid       (pred_valid),
      .pred_ready       (pred_ready),
      .pred_pc          (pred_pc),
      .pred_global      (pred_global),
      .pred_local       (pred_local),
      .pred_taken       (pred_taken),
      .pred_ghr         (pred_ghr),
      .pred_lht         (pred_lht),
      .res_valid        (res_valid),
      .res_ready        (res_ready),
      .res_taken        (res_taken),
      .upd_valid        (upd_valid),
      .upd_pc           (upd_pc),
      .upd_taken        (upd_taken),
      .upd_ghr          (upd_ghr),
      .upd_lht          (upd_lht),
      .choice_upd_en    (choice_upd_en),
      .choice_to_global (choice_to_global),
      .mispredict       (mispredict),
      .restore_ghr      (restore_ghr)
`ifdef TOURNAMENT_STATS_EN
      ,
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_pred(input logic [31:0] pc, input logic g,
                           input logic l, input logic t,
                           input logic [11:0] ghr, input logic [9:0] lht);
      pred_valid  = 1'b1;
      pred_pc     = pc;
      pred_global = g;
      pred_local  = l;
      pred_taken  = t;
      pred_ghr    = ghr;
      pred_lht    = lht;
   endtask

   task automatic push(input logic [31:0] pc);
      set_pred(pc, 1'b1, 1'b1, 1'b1, 12'h000, 10'h000);
      tick();
      pred_valid = 1'b0;
   endtask

   task automatic resolve(input logic t);
      res_valid = 1'b1;
      res_taken = t;
      tick();
      res_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      pred_valid = 0; pred_pc = 0; pred_global = 0; pred_local = 0;
      pred_taken = 0; pred_ghr = 0; pred_lht = 0;
      res_valid = 0; res_taken = 0;
      #12;
      check("rst_upd_valid", 32'(upd_valid), 32'd0);
      check("rst_mispredict", 32'(mispredict), 32'd0);
      check("rst_restore_ghr", 32'(restore_ghr), 32'd0);
      check("rst_pred_ready", 32'(pred_ready), 32'd1);
      check("rst_res_ready", 32'(res_ready), 32'd0);
      reset = 1'b1;
      tick();

      // three correct resolutions
      push(32'h100);
      push(32'h104);
      push(32'h108);
      for (int i = 0; i < 3; i++) begin
         resolve(1'b1);
         check("t1_upd_valid", 32'(upd_valid), 32'd1);
         check("t1_upd_pc", upd_pc, 32'h100 + 32'(4 * i));
         check("t1_mispredict", 32'(mispredict), 32'd0);
         check("t1_choice_en", 32'(choice_upd_en), 32'd0);
      end
      check("t1_res_ready", 32'(res_ready), 32'd0);
      tick();
      check("t1_upd_pulse", 32'(upd_valid), 32'd0);

      // mispredict with choice move toward local
      set_pred(32'h200, 1'b1, 1'b0, 1'b1, 12'h0A5, 10'h3FF);
      tick();
      pred_valid = 1'b0;
      resolve(1'b0);
      check("t2_mispredict", 32'(mispredict), 32'd1);
      check("t2_choice_en", 32'(choice_upd_en), 32'd1);
      check("t2_to_global", 32'(choice_to_global), 32'd0);
      check("t2_restore_ghr", 32'(restore_ghr), 32'h14A);
      check("t2_upd_ghr", 32'(upd_ghr), 32'h0A5);
      check("t2_upd_lht", 32'(upd_lht), 32'h3FF);
      check("t2_upd_taken", 32'(upd_taken), 32'd0);
      check("t2_flush_pred_ready", 32'(pred_ready), 32'd0);
      tick();
      check("t2_mp_pulse", 32'(mispredict), 32'd0);
      check("t2_run_pred_ready", 32'(pred_ready), 32'd1);

      // full queue, refused push with pop
      for (int i = 0; i < 8; i++) push(32'h300 + 32'(4 * i));
      check("t3_full_ready", 32'(pred_ready), 32'd0);
      set_pred(32'h999, 1'b1, 1'b1, 1'b1, 12'h000, 10'h000);
      res_valid = 1'b1;
      res_taken = 1'b1;
      tick();
      res_valid = 1'b0;
      check("t3_pop_pc", upd_pc, 32'h300);
      check("t3_ready_after_pop", 32'(pred_ready), 32'd1);
      tick();
      pred_valid = 1'b0;
      for (int i = 1; i < 8; i++) begin
         resolve(1'b1);
         check("t3_drain_pc", upd_pc, 32'h300 + 32'(4 * i));
      end
      resolve(1'b1);
      check("t3_late_push_pc", upd_pc, 32'h999);
      check("t3_empty", 32'(res_ready), 32'd0);

      // mispredict with simultaneous wrong-path push
      for (int i = 0; i < 4; i++) push(32'h400 + 32'(4 * i));
      set_pred(32'hDEAD, 1'b1, 1'b1, 1'b1, 12'h000, 10'h000);
      res_valid = 1'b1;
      res_taken = 1'b0;
      tick();
      res_valid  = 1'b0;
      pred_valid = 1'b0;
      check("t4_mispredict", 32'(mispredict), 32'd1);
      check("t4_upd_pc", upd_pc, 32'h400);
      check("t4_res_ready_c1", 32'(res_ready), 32'd0);
      tick();
      check("t4_res_ready_c2", 32'(res_ready), 32'd0);
      push(32'h500);
      resolve(1'b1);
      check("t4_no_dead_pc", upd_pc, 32'h500);
      check("t4_empty_after", 32'(res_ready), 32'd0);

      // streaming push/pop across pointer wrap
      push(32'h600);
      for (int i = 1; i <= 20; i++) begin
         set_pred(32'h600 + 32'(4 * i), 1'b1, 1'b1, 1'b1,
                  12'h000, 10'h000);
         res_valid = 1'b1;
         res_taken = 1'b1;
         tick();
         check("t5_stream_pc", upd_pc, 32'h600 + 32'(4 * (i - 1)));
      end
      pred_valid = 1'b0;
      res_valid  = 1'b0;
      resolve(1'b1);
      check("t5_last_pc", upd_pc, 32'h650);
      check("t5_empty", 32'(res_ready), 32'd0);

      // async reset mid-operation
      for (int i = 0; i < 6; i++) push(32'h700 + 32'(4 * i));
      resolve(1'b1);
      check("t6_pre_upd_valid", 32'(upd_valid), 32'd1);
      #1;
      reset = 1'b0;
      #1;
      check("t6_upd_valid", 32'(upd_valid), 32'd0);
      check("t6_upd_pc", upd_pc, 32'd0);
      check("t6_res_ready", 32'(res_ready), 32'd0);
      check("t6_pred_ready", 32'(pred_ready), 32'd1);
      check("t6_restore_ghr", 32'(restore_ghr), 32'd0);
      tick();
      reset = 1'b1;
      tick();
      check("t6_post_res_ready", 32'(res_ready), 32'd0);
      check("t6_post_pred_ready", 32'(pred_ready), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
